alu_seq_n: RTL

//  Parametrised W-bit ALU with a start/busy/done handshake.

---
 rtl/alu_seq_n.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_seq_n.sv
// Parametrised W-bit ALU with a start/busy/done handshake.
// Logic, add/sub and shift ops finish in one cycle; mul (shift-add) and div (restoring) take W cycles.
module alu_seq_n #(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         start,
    input  logic [4:0]   f,
    input  logic         v,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic         dz
);

    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b01100;
    localparam logic [4:0] OP_SHL = 5'b00000;
    localparam logic [4:0] OP_SHR = 5'b10000;
    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_DIV = 5'b00110;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic {IDLE, CALC} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic            v_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [2*W-1:0]  acc;
    logic [W:0]      rem;

    logic [W:0]      sum;
    logic [W:0]      diff;
    logic [W-1:0]    alu_y;
    logic [W:0]      mul_add;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_sh;
    logic [W:0]      div_diff;
    logic            div_ge;
    logic [W:0]      rem_next;
    logic [W-1:0]    quo_next;
    logic [2*W-1:0]  acc_next;
    logic [W-1:0]    calc_y;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        alu_y = '0;
        case (f)
            OP_ADD:  alu_y = v ? {{(W-1){1'b0}}, sum[W]} : sum[W-1:0];
            OP_SUB:  alu_y = v ? {W{diff[W]}} : diff[W-1:0];
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_SHL:  alu_y = {a[W-2:0], 1'b0};
            OP_SHR:  alu_y = {1'b0, a[W-1:1]};
            default: alu_y = '0;
        endcase

        // mul: acc = {partial high, remaining multiplier bits}; add a, then shift right one
        mul_add  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_r} : '0);
        mul_next = {mul_add, acc[W-1:1]};

        // div: quotient bits shift in at acc[0] while dividend bits shift out of acc[W-1]
        div_sh   = {rem[W-1:0], acc[W-1]};
        div_diff = div_sh - {1'b0, b_r};
        div_ge   = (div_sh >= {1'b0, b_r});
        rem_next = div_ge ? div_diff : div_sh;
        quo_next = {acc[W-2:0], div_ge};

        acc_next = is_div ? {{W{1'b0}}, quo_next} : mul_next;
        if (is_div)
            calc_y = v_r ? rem_next[W-1:0] : quo_next;
        else
            calc_y = v_r ? mul_next[2*W-1:W] : mul_next[W-1:0];
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            v_r    <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            rem    <= '0;
            y      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (f == OP_MUL || f == OP_DIV) begin
                            is_div <= (f == OP_DIV);
                            v_r    <= v;
                            a_r    <= a;
                            b_r    <= b;
                            acc    <= (f == OP_DIV) ? {{W{1'b0}}, a} : {{W{1'b0}}, b};
                            rem    <= '0;
                            cnt    <= CW'(W - 1);
                            busy   <= 1'b1;
                            state  <= CALC;
                        end else begin
                            y    <= alu_y;
                            done <= 1'b1;
                            dz   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (is_div)
                        rem <= rem_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        y     <= calc_y;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        dz    <= is_div && (b_r == '0);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
